// File: rtl/ring_pkg.sv
// Shared types and constants for the ring counter checker.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } ring_state_t;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;

  localparam int ERR_CNT_W = 8;

endpackage : ring_pkg

// File: rtl/ring_counter_checker_if.sv
// Bundle of the observed ring code, its sample enable and the checker results.
interface ring_counter_checker_if
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0]         count_in;
  logic                     en;
  logic [$clog2(WIDTH)-1:0] index;
  logic                     locked;
  logic                     onehot_err;
  logic                     seq_err;
  logic                     wrap_pulse;
  logic [ERR_CNT_W-1:0]     err_cnt;

  modport master (
    output count_in, en,
    input  index, locked, onehot_err, seq_err, wrap_pulse, err_cnt
  );

  modport slave (
    input  count_in, en,
    output index, locked, onehot_err, seq_err, wrap_pulse, err_cnt
  );

endinterface : ring_counter_checker_if

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot legality check and binary encode of the set bit.
module ring_onehot_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         code_i,
  output logic                     legal_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW = $clog2(WIDTH);

  always_comb begin
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    legal_o = (code_i != '0) && ((code_i & (code_i - WIDTH'(1))) == '0);
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (code_i[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule : ring_onehot_decode

// File: rtl/ring_counter_checker.sv
// Watches a one-hot ring counter, locks onto its rotation and flags illegal or
// out-of-sequence codes, counting errors with saturation.
module ring_counter_checker
  import ring_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int DIR    = DIR_LEFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     locked,
  output logic                     onehot_err,
  output logic                     seq_err,
  output logic                     wrap_pulse,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_N + 1);

  ring_state_t          state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [GW-1:0]        good_q, good_d;
  logic [IW-1:0]        index_q, index_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 oh_err_q, oh_err_d;
  logic                 seq_err_q, seq_err_d;
  logic                 wrap_q, wrap_d;

  logic             legal;
  logic [IW-1:0]    code_idx;
  logic [WIDTH-1:0] succ;
  logic             wrap_at;

  ring_onehot_decode #(.WIDTH(WIDTH)) u_decode (
    .code_i  (count_in),
    .legal_o (legal),
    .idx_o   (code_idx)
  );

  // A reference of all zeros means "no reference yet"; its successor is never legal.
  generate
    if (DIR == DIR_RIGHT) begin : g_right
      assign succ    = {ref_q[0], ref_q[WIDTH-1:1]};
      assign wrap_at = ref_q[0];
    end else begin : g_left
      assign succ    = {ref_q[WIDTH-2:0], ref_q[WIDTH-1]};
      assign wrap_at = ref_q[WIDTH-1];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    good_d    = good_q;
    index_d   = index_q;
    err_d     = err_q;
    oh_err_d  = 1'b0;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;

    // ERROR is a single-cycle state regardless of en; it always restarts the search.
    if (state_q == ST_ERROR) begin
      state_d = ST_SEARCH;
      ref_d   = '0;
      good_d  = '0;
    end

    if (en) begin
      if (!legal) begin
        oh_err_d = 1'b1;
        if (state_q == ST_LOCKED) state_d = ST_ERROR;
      end else begin
        index_d = code_idx;
        case (state_q)
          ST_SEARCH: begin
            ref_d = count_in;
            if (ref_q != '0 && count_in == succ) begin
              good_d = good_q + GW'(1);
              if (good_q + GW'(1) == GW'(LOCK_N)) state_d = ST_LOCKED;
            end else begin
              good_d = '0;
            end
          end
          ST_LOCKED: begin
            if (count_in == succ) begin
              ref_d  = count_in;
              wrap_d = wrap_at;
            end else begin
              seq_err_d = 1'b1;
              state_d   = ST_ERROR;
            end
          end
          default: ;
        endcase
      end

      if ((oh_err_d || seq_err_d) && err_q != '1) err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      ref_q     <= '0;
      good_q    <= '0;
      index_q   <= '0;
      err_q     <= '0;
      oh_err_q  <= 1'b0;
      seq_err_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      good_q    <= good_d;
      index_q   <= index_d;
      err_q     <= err_d;
      oh_err_q  <= oh_err_d;
      seq_err_q <= seq_err_d;
      wrap_q    <= wrap_d;
    end
  end

  assign index      = index_q;
  assign locked     = (state_q == ST_LOCKED);
  assign onehot_err = oh_err_q;
  assign seq_err    = seq_err_q;
  assign wrap_pulse = wrap_q;
  assign err_cnt    = err_q;

endmodule : ring_counter_checker

// File: tb/tb_ring_counter_checker.sv
// Self-checking bench: directed vector table, saturation and reset sequences,
// then random stimulus against a position-based reference model.
module tb_ring_counter_checker;
  import ring_pkg::*;

  localparam int WIDTH  = 4;
  localparam int LOCK_N = 2;
  localparam int DIR    = DIR_LEFT;

  logic clk;
  logic reset;

  ring_counter_checker_if #(.WIDTH(WIDTH)) bus ();

  ring_counter_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .DIR(DIR)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (bus.count_in),
    .en         (bus.en),
    .index      (bus.index),
    .locked     (bus.locked),
    .onehot_err (bus.onehot_err),
    .seq_err    (bus.seq_err),
    .wrap_pulse (bus.wrap_pulse),
    .err_cnt    (bus.err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Reference model works on bit positions and plain flags.
  int m_ref;      // position of reference code, -1 = none
  int m_good;
  bit m_locked;
  bit m_in_error;
  int m_index;
  bit m_oh, m_seq, m_wrap;
  int m_err;

  function automatic int next_pos(input int p);
    return (DIR == DIR_LEFT) ? (p + 1) % WIDTH : (p + WIDTH - 1) % WIDTH;
  endfunction

  task automatic model_reset();
    m_ref = -1; m_good = 0; m_locked = 0; m_in_error = 0;
    m_index = 0; m_oh = 0; m_seq = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [WIDTH-1:0] c, input bit e);
    int pos;
    bit was_err;
    m_oh = 0; m_seq = 0; m_wrap = 0;
    was_err = m_in_error;
    if (m_in_error) begin
      m_in_error = 0; m_ref = -1; m_good = 0;
    end
    if (!e) return;
    if ($countones(c) != 1) begin
      m_oh = 1;
      if (m_err < 255) m_err++;
      if (m_locked) begin m_locked = 0; m_in_error = 1; end
      return;
    end
    pos = 0;
    for (int i = 0; i < WIDTH; i++) if (c[i]) pos = i;
    m_index = pos;
    if (was_err) return;
    if (m_locked) begin
      if (pos == next_pos(m_ref)) begin
        m_wrap = (DIR == DIR_LEFT) ? (pos == 0) : (pos == WIDTH - 1);
        m_ref  = pos;
      end else begin
        m_seq = 1;
        if (m_err < 255) m_err++;
        m_locked = 0; m_in_error = 1;
      end
    end else if (m_ref >= 0 && pos == next_pos(m_ref)) begin
      m_good++; m_ref = pos;
      if (m_good == LOCK_N) m_locked = 1;
    end else begin
      m_ref = pos; m_good = 0;
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {bus.index, bus.locked, bus.onehot_err, bus.seq_err, bus.wrap_pulse, bus.err_cnt};
  endfunction

  function automatic logic [13:0] model_vec();
    return {2'(m_index), m_locked, m_oh, m_seq, m_wrap, 8'(m_err)};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got={idx,lk,oh,sq,wr,err}=%h required=%h", name, step_no, act, exp);
    end
  endtask

  // Apply one sample and advance one clock; outputs then reflect that sample.
  task automatic step(input logic [WIDTH-1:0] c, input bit e);
    bus.count_in = c;
    bus.en       = e;
    model_step(c, e);
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d code=%b en=%0d idx=%0d lk=%0b oh=%0b sq=%0b wr=%0b err=%0d",
             step_no, c, e, bus.index, bus.locked, bus.onehot_err, bus.seq_err,
             bus.wrap_pulse, bus.err_cnt);
  endtask

  typedef struct {
    logic [3:0] code;
    bit         en;
    logic [1:0] idx;
    bit         lk, oh, sq, wr;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] c, input bit e, input logic [1:0] i,
                     input bit lk, input bit oh, input bit sq, input bit wr, input logic [7:0] er);
    vec_t v;
    v.code = c; v.en = e; v.idx = i; v.lk = lk; v.oh = oh; v.sq = sq; v.wr = wr; v.err = er;
    vecs.push_back(v);
  endtask

  initial begin
    int last_pos;
    logic [3:0] code;
    bit e;
    bit wrap_seen;

    // code en idx lk oh sq wr err
    add(4'b0001, 1, 0, 0, 0, 0, 0, 0);
    add(4'b0010, 1, 1, 0, 0, 0, 0, 0);
    add(4'b0100, 1, 2, 1, 0, 0, 0, 0);
    add(4'b1000, 1, 3, 1, 0, 0, 0, 0);
    add(4'b0001, 1, 0, 1, 0, 0, 1, 0);
    add(4'b0010, 1, 1, 1, 0, 0, 0, 0);
    add(4'b0110, 1, 1, 0, 1, 0, 0, 1);
    add(4'b0000, 0, 1, 0, 0, 0, 0, 1);
    add(4'b0001, 1, 0, 0, 0, 0, 0, 1);
    add(4'b0010, 1, 1, 0, 0, 0, 0, 1);
    add(4'b0100, 1, 2, 1, 0, 0, 0, 1);
    add(4'b1000, 1, 3, 1, 0, 0, 0, 1);
    add(4'b0001, 1, 0, 1, 0, 0, 1, 1);
    add(4'b0010, 1, 1, 1, 0, 0, 0, 1);
    add(4'b1000, 1, 3, 0, 0, 1, 0, 2);
    add(4'b0000, 0, 3, 0, 0, 0, 0, 2);
    add(4'b0001, 1, 0, 0, 0, 0, 0, 2);
    add(4'b0010, 1, 1, 0, 0, 0, 0, 2);
    add(4'b0100, 1, 2, 1, 0, 0, 0, 2);
    add(4'b1000, 0, 2, 1, 0, 0, 0, 2);
    add(4'b1000, 1, 3, 1, 0, 0, 0, 2);
    add(4'b0000, 0, 3, 1, 0, 0, 0, 2);
    add(4'b0001, 1, 0, 1, 0, 0, 1, 2);
    add(4'b0001, 1, 0, 0, 0, 1, 0, 3);
    add(4'b0000, 0, 0, 0, 0, 0, 0, 3);
    add(4'b0000, 1, 0, 0, 1, 0, 0, 4);

    reset        = 1'b1;
    bus.count_in = '0;
    bus.en       = 1'b0;
    model_reset();
    #3;
    check("reset_state", dut_vec(), 14'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].code, vecs[k].en);
      check($sformatf("vec%0d", k), dut_vec(),
            {vecs[k].idx, vecs[k].lk, vecs[k].oh, vecs[k].sq, vecs[k].wr, vecs[k].err});
    end

    // Long run of all-zero codes: err_cnt must saturate, never wrap.
    wrap_seen = 0;
    for (int k = 0; k < 300; k++) begin
      step(4'b0000, 1);
      check("sat_run", dut_vec(), model_vec());
      if (bus.wrap_pulse) wrap_seen = 1;
    end
    check("sat_255", {6'h0, bus.err_cnt}, 14'd255);
    check("sat_no_wrap", {13'h0, wrap_seen}, 14'h0);

    // Lock, then assert reset between edges: outputs clear without a clock edge.
    step(4'b0001, 1);
    step(4'b0010, 1);
    step(4'b0100, 1);
    check("prelock", {13'h0, bus.locked}, 14'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_vec(), 14'h0);
    #2;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(4'($urandom_range(0, 15)), 0);
      check("idle_no_pulse", dut_vec(), 14'h0);
    end
    // Relock needs the full sequence again.
    step(4'b1000, 1);
    check("relock_a", dut_vec(), model_vec());
    step(4'b0001, 1);
    check("relock_b", {13'h0, bus.locked}, 14'h0);
    step(4'b0010, 1);
    check("relock_c", dut_vec(), {2'd1, 1'b1, 11'h0});

    // Random stimulus, mostly correct successors so lock is reached often.
    last_pos = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        last_pos = next_pos(last_pos);
        code = 4'(1 << last_pos);
      end else begin
        code = 4'($urandom_range(0, 15));
        for (int i = 0; i < WIDTH; i++) if (code[i]) last_pos = i;
      end
      e = ($urandom_range(0, 99) < 85);
      step(code, e);
      check("random", dut_vec(), model_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ring_counter_checker

// File: doc/ring_counter_checker.md
RING_COUNTER_CHECKER -- requirements
Module: ring_counter_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, ring length (number of one-hot bits, >=2).
REQ-002 SHALL have parameter LOCK_N, default 2, consecutive correct successor codes required to declare lock.
REQ-003 SHALL have parameter DIR, default 0, expected rotation direction (0 = rotate left, LSB toward MSB; 1 = rotate right).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port count_in, input, WIDTH, ring counter code under observation.
REQ-007 SHALL have port en, input, 1, sample enable; count_in evaluated only when 1.
REQ-008 SHALL have port index, output, clog2(WIDTH), binary position of the set bit in the last legal code.
REQ-009 SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-010 SHALL have port onehot_err, output, 1, one-cycle pulse: sampled code not exactly one bit set.
REQ-011 SHALL have port seq_err, output, 1, one-cycle pulse: legal code that is not the expected successor while LOCKED.
REQ-012 SHALL have port wrap_pulse, output, 1, one-cycle pulse on index WIDTH-1 -> 0 (DIR=0) or 0 -> WIDTH-1 (DIR=1) while LOCKED.
REQ-013 SHALL have port err_cnt, output, 8, saturating count of flagged errors.

Function
REQ-014 All outputs SHALL be registered; response to a sample SHALL appear one clk after the edge on which en=1 sampled it.
REQ-015 FSM states SHALL be SEARCH, LOCKED, ERROR.
REQ-016 SEARCH: first legal code SHALL be captured as reference with good_cnt=0; each following legal expected successor SHALL increment good_cnt; any other legal code SHALL become the new reference with good_cnt=0.
REQ-017 SEARCH -> LOCKED SHALL occur on the sample that brings good_cnt to LOCK_N.
REQ-018 LOCKED: expected successor SHALL keep LOCKED; an illegal code or a wrong successor (including a repeated code) SHALL move to ERROR.
REQ-019 ERROR SHALL last exactly one clk, then go to SEARCH with good_cnt=0 and the reference cleared.
REQ-020 onehot_err SHALL be flagged in every state; all-zero input SHALL count as illegal.
REQ-021 When a code is both illegal and out of sequence, only onehot_err SHALL pulse, and err_cnt SHALL increment once.
REQ-022 err_cnt SHALL increment by 1 per onehot_err or seq_err pulse and saturate at 255.
REQ-023 index SHALL update only on legal codes and hold its value on illegal codes.
REQ-024 With en=0, state, index, reference and err_cnt SHALL hold, and pulse outputs SHALL be 0.

Reset
REQ-025 reset=1 SHALL immediately, without a clk edge, force: state SEARCH, index 0, locked 0, onehot_err 0, seq_err 0, wrap_pulse 0, err_cnt 0, reference 0, good_cnt 0.
REQ-026 Reset asserted mid-lock SHALL discard lock; relock SHALL require the full REQ-016/017 sequence.

Structure
REQ-027 Package ring_pkg SHALL hold the state enumeration, the DIR_LEFT/DIR_RIGHT constants and the err_cnt width constant.
REQ-028 Combinational sub-module ring_onehot_decode SHALL perform the one-hot legality check and the binary encode; the successor compare and FSM SHALL live in ring_counter_checker.

Verification (WIDTH=4, LOCK_N=2, DIR=0)
REQ-029 Release reset, en=1, drive 0001,0010,0100 -> locked=1 one clk after the 0100 sample; index 0,1,2; no errors.
REQ-030 Locked, drive 1000,0001 -> index 3 then 0; wrap_pulse high exactly one clk, aligned with index=0.
REQ-031 Locked, drive 0110 -> onehot_err one clk, err_cnt=1, locked=0 next clk, index holds.
REQ-032 Locked at 0010, drive 1000 -> seq_err one clk, err_cnt +1, locked drops; then 0001,0010,0100 -> relock.
REQ-033 Drive 0000 for 300 sampled cycles -> err_cnt stops at 255; no wrap.
REQ-034 Assert reset between clk edges while locked -> all outputs 0 before the next edge; en=0 cycles produce no pulses.
